// File: rtl/spi_bus_bridge_if.sv
// Z180 I/O bus as seen by the SPI bridge: address/data, active-low strobes,
// and the read-data / WAIT drive controls returned to the CPU side.
interface spi_bus_bridge_if;
  logic [7:0] A;
  logic [7:0] D;
  logic       IORQ;
  logic       RD;
  logic       WR;
  logic       M1;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic       WAIT_OE;

  modport master (output A, D, IORQ, RD, WR, M1, input D_OUT, D_OE, WAIT_OE);
  modport slave  (input A, D, IORQ, RD, WR, M1, output D_OUT, D_OE, WAIT_OE);
endinterface

// File: rtl/spi_bus_bridge.sv
// Z180 I/O-port front end for the SPI master: DATA at BASE_ADDR, CTRL/STATUS at BASE_ADDR+1.
// Define SPI_IRQ_EN to add the INT_N output, the CTRL bit1 interrupt enable and the irq flag.
module spi_bus_bridge #(
  parameter logic [7:0]  BASE_ADDR   = 8'h80,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   CLK1,
  input  logic                   RESET_N,
  spi_bus_bridge_if.slave        bus,
  output logic                   spi_active,
  output logic                   spi_start,
  output logic [7:0]             spi_output,
  input  logic [7:0]             spi_input,
  input  logic                   spi_done
`ifdef SPI_IRQ_EN
  ,
  output logic                   INT_N
`endif
);
  localparam logic [7:0] CTRL_ADDR = BASE_ADDR + 8'd1;

  typedef enum logic [1:0] {IDLE, BUSY, STALL} state_t;
  state_t state, state_n;

  logic [SYNC_STAGES-1:0] iorq_sync, rd_sync, wr_sync, m1_sync;
  logic       s_iorq, s_rd, s_wr, s_m1;
  logic       acc, acc_q, acc_rise, live_ctrl;
  logic [7:0] op_addr, op_data;
  logic       op_dir;
  logic [7:0] tx, rx, d_out, status;
  logic       ss_en, irq_flag, rd_hit, wait_oe, start;
  logic       done_taken, exec_fire, exec_ctrl, exec_rd;
  logic [7:0] exec_data;

  assign s_iorq    = iorq_sync[SYNC_STAGES-1];
  assign s_rd      = rd_sync[SYNC_STAGES-1];
  assign s_wr      = wr_sync[SYNC_STAGES-1];
  assign s_m1      = m1_sync[SYNC_STAGES-1];
  assign live_ctrl = (bus.A == CTRL_ADDR);
  assign acc       = !s_iorq && s_m1 && (!s_rd || !s_wr) && ((bus.A == BASE_ADDR) || live_ctrl);
  assign acc_rise  = acc && !acc_q;
  assign status    = {state != IDLE, 5'b0, irq_flag, ss_en};

  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_n;
  end

  // A STATUS read never stalls; a transfer ending on the access edge lets the access run as if idle.
  always_comb begin
    state_n    = state;
    done_taken = 1'b0;
    exec_fire  = 1'b0;
    exec_ctrl  = live_ctrl;
    exec_rd    = !s_rd;
    exec_data  = bus.D;
    unique case (state)
      IDLE: if (acc_rise) exec_fire = 1'b1;
      BUSY: begin
        if (spi_done) begin
          done_taken = 1'b1;
          state_n    = IDLE;
        end
        if (acc_rise) begin
          if (spi_done || (live_ctrl && !s_rd)) exec_fire = 1'b1;
          else                                   state_n   = STALL;
        end
      end
      STALL: begin
        exec_ctrl = (op_addr == CTRL_ADDR);
        exec_rd   = op_dir;
        exec_data = op_data;
        if (spi_done) begin
          done_taken = 1'b1;
          exec_fire  = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (exec_fire && !exec_ctrl && !exec_rd) state_n = BUSY;
  end

  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      iorq_sync <= '1;
      rd_sync   <= '1;
      wr_sync   <= '1;
      m1_sync   <= '1;
      acc_q     <= 1'b0;
      op_addr   <= '0;
      op_dir    <= 1'b0;
      op_data   <= '0;
      tx        <= '0;
      rx        <= '0;
      d_out     <= '0;
      ss_en     <= 1'b0;
      rd_hit    <= 1'b0;
      wait_oe   <= 1'b0;
      start     <= 1'b0;
    end else begin
      iorq_sync <= {iorq_sync[SYNC_STAGES-2:0], bus.IORQ};
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], bus.RD};
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], bus.WR};
      m1_sync   <= {m1_sync[SYNC_STAGES-2:0], bus.M1};
      acc_q     <= acc;
      if (acc_rise) begin
        op_addr <= bus.A;
        op_dir  <= !s_rd;
        op_data <= bus.D;
      end
      if (done_taken) rx <= spi_input;
      start   <= exec_fire && !exec_ctrl && !exec_rd;
      wait_oe <= (state_n == STALL);
      rd_hit  <= (rd_hit && acc) || (exec_fire && exec_rd);
      if (exec_fire) begin
        unique case ({exec_ctrl, exec_rd})
          2'b11:   d_out <= status;
          2'b10:   ss_en <= exec_data[0];
          2'b01:   d_out <= done_taken ? spi_input : rx;
          default: tx    <= exec_data;
        endcase
      end
    end
  end

`ifdef SPI_IRQ_EN
  logic irq_en;

  // A DATA access in the same cycle as a completion wins over setting the flag.
  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_en   <= 1'b0;
      irq_flag <= 1'b0;
    end else begin
      if (exec_fire && exec_ctrl && !exec_rd) irq_en <= exec_data[1];
      if (exec_fire && !exec_ctrl)            irq_flag <= 1'b0;
      else if (done_taken)                    irq_flag <= 1'b1;
    end
  end

  assign INT_N = !(irq_flag && irq_en);
`else
  assign irq_flag = 1'b0;
`endif

  assign spi_active  = ss_en;
  assign spi_output  = tx;
  assign spi_start   = start;
  assign bus.D_OUT   = d_out;
  assign bus.D_OE    = rd_hit && !bus.RD && !bus.IORQ;
  assign bus.WAIT_OE = wait_oe;
endmodule

// File: tb/tb_spi_bus_bridge.sv
// Scoreboard bench for spi_bus_bridge: CPU bus tasks queue expected starts/reads,
// a monitor pops and compares, and an SPI master model answers each start.
`timescale 1ns/1ps
module tb_spi_bus_bridge;
  localparam logic [7:0]  BASE = 8'h80;
  localparam logic [7:0]  CTRL = 8'h81;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_active, spi_start, spi_done;
  logic [7:0] spi_output, spi_input;

  spi_bus_bridge_if bus();

  spi_bus_bridge #(.BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
    .CLK1       (clk),
    .RESET_N    (rst_n),
    .bus        (bus),
    .spi_active (spi_active),
    .spi_start  (spi_start),
    .spi_output (spi_output),
    .spi_input  (spi_input),
    .spi_done   (spi_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic ss; } start_t;
  typedef struct { logic [7:0] data; logic [7:0] mask; } rd_t;
  typedef struct { logic [7:0] ret; int unsigned delay; } xfer_t;

  start_t     start_q[$];
  rd_t        read_q[$];
  xfer_t      xfer_q[$];
  logic [7:0] model_rx;
  logic       model_ss;
  bit         master_busy;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every start and every rising D_OE must match the oldest queued expectation.
  logic       doe_q = 1'b0;
  logic [7:0] hold_exp = '0, hold_mask = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_start) begin
        if (start_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start got %h expected none", spi_output);
        end else begin
          start_t s;
          s = start_q.pop_front();
          check("start_byte_ss", {7'b0, spi_active, spi_output}, {7'b0, s.ss, s.data});
        end
      end
      if (bus.D_OE && !doe_q) begin
        if (read_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_doe got %h expected none", bus.D_OUT);
        end else begin
          rd_t r;
          r = read_q.pop_front();
          hold_exp  = r.data;
          hold_mask = r.mask;
          check("read_data", {8'h00, bus.D_OUT & r.mask}, {8'h00, r.data & r.mask});
        end
      end else if (bus.D_OE && doe_q) begin
        check("read_hold", {8'h00, bus.D_OUT & hold_mask}, {8'h00, hold_exp & hold_mask});
      end
    end
    doe_q = rst_n ? bus.D_OE : 1'b0;
  end

  // SPI master model: answer each start after the queued delay with the queued byte.
  initial begin
    spi_done    = 1'b0;
    spi_input   = 8'h00;
    master_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) begin
        xfer_t x;
        master_busy = 1'b1;
        if (xfer_q.size() != 0) x = xfer_q.pop_front();
        else                    x = '{ret: 8'h00, delay: 10};
        repeat (x.delay) @(posedge clk);
        #2 spi_input = x.ret; spi_done = 1'b1;
        @(posedge clk);
        #2 spi_done = 1'b0; spi_input = 8'($urandom); master_busy = 1'b0;
      end
    end
  end

  task automatic io_cycle(input logic [7:0] addr, input logic [7:0] data, input bit is_rd,
                          input bit intack, output bit saw_wait);
    int unsigned n;
    saw_wait = 1'b0;
    @(posedge clk); #2;
    bus.A = addr;
    bus.D = data;
    @(posedge clk); #2;
    bus.IORQ = 1'b0;
    if (intack) bus.M1 = 1'b0;
    if (is_rd) bus.RD = 1'b0;
    else       bus.WR = 1'b0;
    repeat (SYNC + 4) begin
      @(posedge clk); #1;
      if (bus.WAIT_OE) saw_wait = 1'b1;
    end
    n = 0;
    while (bus.WAIT_OE && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.WAIT_OE) begin
      checks++; errors++;
      $display("FAIL wait_timeout got WAIT_OE=1 expected release within 3000 cycles");
    end
    repeat (2) @(posedge clk);
    #2;
    bus.RD = 1'b1; bus.WR = 1'b1; bus.IORQ = 1'b1; bus.M1 = 1'b1;
    #1;
    if (is_rd) check("doe_release", {15'b0, bus.D_OE}, 16'h0000);
    repeat (SYNC + 3) @(posedge clk);
  endtask

  task automatic data_write(input logic [7:0] d, input logic [7:0] ret, input int unsigned dly,
                            output bit w);
    xfer_q.push_back('{ret: ret, delay: dly});
    start_q.push_back('{data: d, ss: model_ss});
    model_rx = ret;
    io_cycle(BASE, d, 1'b0, 1'b0, w);
  endtask

  task automatic data_read(output bit w);
    read_q.push_back('{data: model_rx, mask: 8'hFF});
    io_cycle(BASE, 8'h00, 1'b1, 1'b0, w);
  endtask

  task automatic ctrl_write(input logic [7:0] d);
    bit w;
    model_ss = d[0];
    io_cycle(CTRL, d, 1'b0, 1'b0, w);
  endtask

  task automatic status_read(input logic busy, input logic [7:0] mask);
    bit w;
    read_q.push_back('{data: {busy, 6'b0, model_ss}, mask: mask});
    io_cycle(CTRL, 8'h00, 1'b1, 1'b0, w);
    check("status_no_wait", {15'b0, w}, 16'h0000);
  endtask

  task automatic wait_master_idle();
    int unsigned n;
    n = 0;
    while (master_busy && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (master_busy) begin
      checks++; errors++;
      $display("FAIL master_timeout got busy expected idle within 5000 cycles");
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check(name, {4'b0, bus.D_OE, bus.WAIT_OE, spi_active, spi_start, bus.D_OUT}, 16'h0000);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got no finish expected finish before 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w, w1;
    bit fork_done;
    int unsigned n;
    bus.A = '0; bus.D = '0;
    bus.IORQ = 1'b1; bus.RD = 1'b1; bus.WR = 1'b1; bus.M1 = 1'b1;
    model_rx = '0;
    model_ss = 1'b0;
    fork_done = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    status_read(1'b0, 8'hFF);

    ctrl_write(8'h01);
    data_write(8'hA5, 8'h3C, 150, w);
    check("first_write_no_wait", {15'b0, w}, 16'h0000);
    status_read(1'b1, 8'hFF);
    wait_master_idle();
    data_read(w);
    check("idle_read_no_wait", {15'b0, w}, 16'h0000);

    data_write(8'h11, 8'h66, 100, w1);
    data_write(8'h22, 8'h99, 20, w);
    check("write_no_wait", {15'b0, w1}, 16'h0000);
    check("write_while_busy_wait", {15'b0, w}, 16'h0001);
    wait_master_idle();

    data_write(8'h77, 8'h5A, 100, w);
    data_read(w);
    check("read_while_busy_wait", {15'b0, w}, 16'h0001);
    wait_master_idle();

    io_cycle(8'h82, 8'h00, 1'b0, 1'b0, w);
    check("foreign_write_no_wait", {15'b0, w}, 16'h0000);
    io_cycle(8'h82, 8'h00, 1'b1, 1'b0, w);
    io_cycle(BASE, 8'h99, 1'b0, 1'b1, w);
    check("intack_write_no_wait", {15'b0, w}, 16'h0000);
    io_cycle(BASE, 8'h00, 1'b1, 1'b1, w);
    status_read(1'b0, 8'hFF);
    data_read(w);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       data_write(8'($urandom), 8'($urandom), $urandom_range(4, 60), w);
        1:       data_read(w);
        2:       ctrl_write(8'($urandom));
        default: status_read(1'b0, 8'h7F);
      endcase
    end
    wait_master_idle();

    data_write(8'h5C, 8'hEE, 200, w);
    fork
      begin
        bit w2;
        data_write(8'h6D, 8'h44, 10, w2);
        check("stall_before_reset", {15'b0, w2}, 16'h0001);
        fork_done = 1'b1;
      end
    join_none
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("wait_held_in_stall", {15'b0, bus.WAIT_OE}, 16'h0001);
    @(posedge clk); #2 rst_n = 1'b0;
    check_reset_outputs("reset_mid_stall");
    n = 0;
    while (!fork_done && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (!fork_done) begin
      checks++; errors++;
      $display("FAIL stalled_cycle_timeout got pending expected released by reset");
    end
    start_q.delete();
    read_q.delete();
    xfer_q.delete();
    model_rx = '0;
    model_ss = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    wait_master_idle();
    status_read(1'b0, 8'hFF);
    data_read(w);
    repeat (10) @(posedge clk);

    check("start_queue_empty", 16'(start_q.size()), 16'h0000);
    check("read_queue_empty", 16'(read_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
